// File: rtl/imem_sync.sv
// Synchronous instruction memory: registered, stall-aware fetch port, program-load port and a
// post-reset clear sweep. Define IMEM_PARITY_EN to store a parity bit per entry and report err.
module imem_sync #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 6,
  parameter int RESET_VEC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W+1:0] addr,
  input  logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              misalign,
  output logic              ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              err
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  if (RESET_VEC < 0 || RESET_VEC >= DEPTH) begin : g_bad_reset_vec
    $error("imem_sync: RESET_VEC outside memory");
  end

  // state   | meaning
  // S_CLEAR | sweeping zeros into every entry, fetch and load ignored
  // S_READY | memory initialised, fetch and load accepted
  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic              clr_we;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] ridx;
  logic [MEM_W-1:0]  wdata;
  logic [MEM_W-1:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == S_CLEAR && cnt == ADDR_W'(DEPTH - 1)) state_nx = S_READY;
  end

  always_comb begin
    ready  = 1'b0;
    clr_we = 1'b0;
    case (state)
      S_CLEAR: clr_we = 1'b1;
      S_READY: ready  = 1'b1;
      default: ;
    endcase
  end

  // Clear and load writes never coincide: one is only active in each state.
  assign we    = clr_we | (ready & ld_en);
  assign waddr = clr_we ? cnt : ld_addr;
`ifdef IMEM_PARITY_EN
  assign wdata = clr_we ? '0 : {^ld_data, ld_data};
`else
  assign wdata = clr_we ? '0 : ld_data;
`endif
  assign ridx  = addr[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first: the fetch register samples the entry before a same-edge load lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
    end else if (!stall) begin
      if (ready && req) begin
        rdata    <= mem[ridx][DATA_W-1:0];
        rvalid   <= 1'b1;
        misalign <= |addr[1:0];
      end else begin
        rvalid   <= 1'b0;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (!stall && ready && req) begin
      err <= ^mem[ridx];
    end
  end

  // Debug hook: corrupt the stored parity bit of one entry.
  task automatic flip_parity(input logic [ADDR_W-1:0] idx);
    mem[idx][DATA_W] <= ~mem[idx][DATA_W];
  endtask
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_sync.sv
// Randomised scoreboard bench for imem_sync; reference memory is a plain array updated
// from the fetch/load rules, expected responses are queued and checked by a monitor.
module tb_imem_sync;
  logic        clk;
  logic        rst_n;
  logic        req;
  logic [7:0]  addr;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misalign;
  logic        ready;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic        err;

  imem_sync #(.DATA_W(32), .ADDR_W(6), .RESET_VEC(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .stall(stall),
    .rdata(rdata), .rvalid(rvalid), .misalign(misalign), .ready(ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        m;
    logic        e;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [64];
  logic        bad [64];
  logic        model_ready;
  int          clr_cnt;
  logic        last_stall;
  int          checks;
  int          errors;

  logic        cur_v;
  logic [31:0] cur_d;
  logic        cur_m;
  logic        cur_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = '0;
      bad[i]     = 1'b0;
    end
    model_ready = 1'b0;
    clr_cnt     = 0;
    last_stall  = 1'b0;
    q.delete();
  endtask

  task automatic step(input logic r, input logic [7:0] a, input logic s,
                      input logic le, input logic [5:0] la, input logic [31:0] ld);
    req = r; addr = a; stall = s; ld_en = le; ld_addr = la; ld_data = ld;
    @(posedge clk);
    if (rst_n) begin
      if (model_ready) begin
        if (r && !s) q.push_back({ref_mem[a[7:2]], |a[1:0], bad[a[7:2]]});
        if (le) begin
          ref_mem[la] = ld;
          bad[la]     = 1'b0;
        end
      end else begin
        clr_cnt++;
        if (clr_cnt == 64) model_ready = 1'b1;
      end
      last_stall = s;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    step(1'b1, 8'h00, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic sweep_and_check();
    for (int i = 0; i < 63; i++) idle();
    chk("ready_before_64", {31'b0, ready}, 32'h0);
    idle();
    chk("ready_after_64", {31'b0, ready}, 32'h1);
  endtask

  task automatic random_phase(input int n);
    logic       r, s, le;
    logic [7:0] a;
    logic [5:0] la;
    for (int i = 0; i < n; i++) begin
      r  = ($urandom_range(9) < 7);
      s  = ($urandom_range(9) < 2);
      le = ($urandom_range(9) < 3);
      a  = 8'($urandom);
      la = 6'($urandom);
      if ($urandom_range(3) == 0) la = a[7:2];
      step(r, a, s, le, la, $urandom);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_v = 1'b0; cur_d = '0; cur_m = 1'b0; cur_e = 1'b0;
    end else begin
      if (!last_stall) begin
        if (rvalid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rvalid: got rvalid 1 expected no response at %0t", $time);
          end else begin
            {cur_d, cur_m, cur_e} = q.pop_front();
            cur_v = 1'b1;
          end
        end else begin
          if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL missing_rvalid: got rvalid 0 expected response %h at %0t", q[0].d, $time);
            void'(q.pop_front());
          end
          cur_v = 1'b0;
        end
      end
      chk("ready", {31'b0, ready}, {31'b0, model_ready});
      chk("rvalid", {31'b0, rvalid}, {31'b0, cur_v});
      chk("rdata", rdata, cur_d);
      chk("misalign", {31'b0, misalign}, {31'b0, cur_m});
      chk("err", {31'b0, err}, {31'b0, cur_e});
    end
  end

  initial begin
    checks = 0; errors = 0;
    req = 0; addr = 0; stall = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    sweep_and_check();

    step(1'b1, 8'h00, 1'b0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 8'h7C, 1'b0, 1'b0, 6'd0, 32'h0);
    idle();

    step(1'b0, 8'h00, 1'b0, 1'b1, 6'd0, 32'h20080020);
    step(1'b0, 8'h00, 1'b0, 1'b1, 6'd1, 32'h20090037);
    step(1'b1, 8'h04, 1'b0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 8'h06, 1'b0, 1'b0, 6'd0, 32'h0);
    idle();

    step(1'b1, 8'h00, 1'b0, 1'b0, 6'd0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h04, 1'b1, 1'b0, 6'd0, 32'h0);
    step(1'b1, 8'h04, 1'b0, 1'b0, 6'd0, 32'h0);
    idle();

    step(1'b1, 8'h08, 1'b0, 1'b1, 6'd2, 32'h01094020);
    step(1'b1, 8'h08, 1'b0, 1'b0, 6'd0, 32'h0);
    idle();

`ifdef IMEM_PARITY_EN
    step(1'b0, 8'h00, 1'b0, 1'b1, 6'd3, 32'h12345678);
    step(1'b0, 8'h00, 1'b0, 1'b1, 6'd4, 32'h0F0F0F01);
    dut.flip_parity(6'd3);
    bad[3] = 1'b1;
    step(1'b1, 8'h0C, 1'b0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 8'h10, 1'b0, 1'b0, 6'd0, 32'h0);
    idle();
`endif

    random_phase(400);

    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 6'(i), 32'hA5A50000 + i);
    do_reset();
    sweep_and_check();
    step(1'b1, 8'h00, 1'b0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 8'h0C, 1'b0, 1'b0, 6'd0, 32'h0);
    idle();

    random_phase(150);
    idle();
    idle();
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
- Parametrised, synthesizable instruction memory for the pipelined CPU. Successor to the 64x32 asynchronous-read instruction memory.
- Byte-addressed fetch port with registered read, one-cycle latency, and a stall-aware output register.
- Has a program-load write port and a hardware clear sweep after reset, replacing simulation-only initial blocks.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 6, word-address bits; DEPTH = 2**ADDR_W entries.
- RESET_VEC, 0, word address that is fetched and checked first after reset; informational only, drives no logic.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  fetch request.
- addr  in  ADDR_W+2  byte address; bits [1:0] are the byte offset, bits [ADDR_W+1:2] are the word index.
- stall  in  1  hold the current output; downstream not accepting.
- rdata  out  DATA_W  fetched instruction.
- rvalid  out  1  rdata is valid.
- misalign  out  1  the returned fetch had addr[1:0] != 0.
- ready  out  1  memory initialised; accepts req and ld_en.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  ADDR_W  load word index.
- ld_data  in  DATA_W  load word.
- err  out  1  parity error on the returned fetch (optional feature).

Behaviour:
- Reset is asynchronous, active-low. While asserted:
  - rdata=0, rvalid=0, misalign=0, err=0, ready=0.
  - FSM enters CLEAR; clear counter = 0.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. When cnt == DEPTH-1 the write occurs and the FSM moves to READY. CLEAR lasts exactly DEPTH cycles after reset release. req and ld_en are ignored during CLEAR.
  - READY: ready=1. The FSM stays here until the next reset.
- Fetch, in READY with stall=0:
  - req sampled at edge N: at edge N+1, rdata = mem[addr[ADDR_W+1:2]], rvalid=1, misalign = |addr[1:0].
  - A misaligned fetch still returns the word at the truncated index.
  - req=0 with stall=0: rvalid goes to 0 next edge; rdata holds its last value.
- Stall:
  - While stall=1, rdata, rvalid, misalign and err hold.
  - req is ignored and not queued; the PC stage must re-present the request.
- Load:
  - ld_en in READY writes ld_data to mem[ld_addr] at the edge.
  - Load and fetch can occur in the same cycle.
  - Same index in the same cycle: read-first, so the fetch returns the old word and the new word is visible from the next request.
- Address wrap: the word index is exactly ADDR_W bits; byte-address bits above ADDR_W+1 do not exist, so there is no out-of-range case.
- Reset mid-operation:
  - Outputs clear immediately and the clear sweep restarts from 0.
  - Any partially loaded program is lost.
  - A load in the reset cycle is discarded.
- Memory is inferred as a single-port-write / single-port-read synchronous RAM.
- The CLEAR write and the load write are mutually exclusive by state.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each entry stores DATA_W+1 bits; the extra bit is the even parity (XOR) of the data word.
  - Parity is generated on load and on clear (parity of 0 = 0).
  - On fetch, err = XOR(stored word, stored parity bit), registered with rdata and held under stall like rdata.
  - A debug-only task/force path flips a stored parity bit for test.
- Not defined: no extra storage; err is tied to 0.

Test Plan:
- Reset release with ADDR_W=6:
  - ready=0 for exactly 64 cycles, then 1.
  - Fetching addr=0x00, 0x7C returns rdata=0x00000000 with rvalid=1 one cycle after each req.
- Load, then fetch:
  - ld_addr=0 with 0x20080020, ld_addr=1 with 0x20090037.
  - req addr=0x04 -> next cycle rdata=0x20090037, rvalid=1, misalign=0.
- Misaligned fetch: req addr=0x06 after the load above -> rdata=0x20090037, misalign=1.
- Stall:
  - req addr=0x00, then stall=1 for 3 cycles while addr=0x04.
  - rdata stays 0x20080020 with rvalid=1 throughout.
  - After stall drops, with req re-asserted -> rdata=0x20090037.
- Simultaneous load/fetch to index 2:
  - Old 0x0, load 0x01094020 with req addr=0x08 -> rdata=0x00000000.
  - The next req to addr=0x08 -> rdata=0x01094020.
- Reset mid-load, then parity:
  - Pulse rst_n low after loading 4 words -> all outputs 0 at once; after the 64-cycle sweep, a fetch at addr=0x00 returns 0.
  - With IMEM_PARITY_EN defined, corrupt the parity bit of entry 3 and fetch addr=0x0C -> err=1; an uncorrupted entry gives err=0.
